// File: rtl/online_dual_tap.sv
// Two-tap signed-digit online FIR section: data_out = x[n] + 178*x[n-1] + 135*x[n-2].
// Includes the shared leaf cells online_adder, online_ccm_178 and online_ccm_135.

module online_adder #(
    parameter int N = 8
) (
    input  logic [2*N-1:0] x,
    input  logic [2*N-1:0] y,
    input  logic           cin,
    output logic [2*N+1:0] z
);
    // Per-digit position sum t in {-2..2}, split into transfer c and interim w.
    // The choice for |t|=1 looks at the sign of the lower position's sum so that
    // w + incoming transfer always stays within a single signed digit.
    logic [N-1:0] ge0, le0, cp, cm, wp, wm;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digit
            logic [2:0] t;
            logic       lo_ge0, lo_le0, ci_p, ci_m;

            assign t = {2'b00, x[2*gi+1]} - {2'b00, x[2*gi]}
                     + {2'b00, y[2*gi+1]} - {2'b00, y[2*gi]};
            assign ge0[gi] = ~t[2];
            assign le0[gi] = t[2] | (t == 3'b000);

            // The LSD's incoming transfer is cin, which is never negative.
            if (gi == 0) begin : g_lsd
                assign lo_ge0 = 1'b1;
                assign lo_le0 = 1'b0;
                assign ci_p   = cin;
                assign ci_m   = 1'b0;
            end else begin : g_upper
                assign lo_ge0 = ge0[gi-1];
                assign lo_le0 = le0[gi-1];
                assign ci_p   = cp[gi-1];
                assign ci_m   = cm[gi-1];
            end

            assign cp[gi] = (t == 3'b010) | ((t == 3'b001) & lo_ge0);
            assign cm[gi] = (t == 3'b110) | ((t == 3'b111) & lo_le0);
            assign wp[gi] = ((t == 3'b001) & ~lo_ge0) | ((t == 3'b111) & lo_le0);
            assign wm[gi] = ((t == 3'b001) & lo_ge0) | ((t == 3'b111) & ~lo_le0);

            assign z[2*gi+1] = (wp[gi] & ~ci_m) | (~wp[gi] & ~wm[gi] & ci_p);
            assign z[2*gi]   = (wm[gi] & ~ci_p) | (~wp[gi] & ~wm[gi] & ci_m);
        end
    endgenerate

    assign z[2*N+1] = cp[N-1];
    assign z[2*N]   = cm[N-1];
endmodule

module online_ccm_178 #(
    parameter int N = 8
) (
    input  logic [2*N-1:0]     x,
    output logic [2*(N+9)-1:0] y
);
    // 178x = ((x + 4x) << 5) + ((x + 8x) << 1)
    logic [2*(N+3)-1:0] c;
    logic [2*(N+4)-1:0] d;

    online_adder #(.N(N+2)) u_c (
        .x   ({x, 4'b0}),
        .y   ({4'b0, x}),
        .cin (1'b0),
        .z   (c)
    );

    online_adder #(.N(N+3)) u_d (
        .x   ({x, 6'b0}),
        .y   ({6'b0, x}),
        .cin (1'b0),
        .z   (d)
    );

    online_adder #(.N(N+8)) u_y (
        .x   ({c, 10'b0}),
        .y   ({6'b0, d, 2'b0}),
        .cin (1'b0),
        .z   (y)
    );
endmodule

module online_ccm_135 #(
    parameter int N = 8
) (
    input  logic [2*N-1:0]     x,
    output logic [2*(N+9)-1:0] y
);
    // 135x = (x << 7) + ((x << 3) - x); negation swaps each digit's plus/minus bits.
    logic [2*N-1:0]     nx;
    logic [2*(N+4)-1:0] e;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_neg
            assign nx[2*gi+1] = x[2*gi];
            assign nx[2*gi]   = x[2*gi+1];
        end
    endgenerate

    online_adder #(.N(N+3)) u_e (
        .x   ({x, 6'b0}),
        .y   ({6'b0, nx}),
        .cin (1'b0),
        .z   (e)
    );

    online_adder #(.N(N+8)) u_y (
        .x   ({2'b0, x, 14'b0}),
        .y   ({8'b0, e}),
        .cin (1'b0),
        .z   (y)
    );
endmodule

module online_dual_tap #(
    parameter int STAGE = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable,
    input  logic [2*STAGE-1:0]      din_x,
    output logic [2*(STAGE+11)-1:0] data_out
);
    logic [2*STAGE-1:0]      x1_reg, x2_reg;
    logic [2*(STAGE+9)-1:0]  p1, p2;
    logic [2*(STAGE+10)-1:0] s;

    // A low enable clears the delay line rather than holding it.
    always_ff @(posedge clk) begin
        if (!nrst || !enable) begin
            x1_reg <= '0;
            x2_reg <= '0;
        end else begin
            x1_reg <= din_x;
            x2_reg <= x1_reg;
        end
    end

    online_ccm_178 #(.N(STAGE)) u_p1 (
        .x (x1_reg),
        .y (p1)
    );

    online_ccm_135 #(.N(STAGE)) u_p2 (
        .x (x2_reg),
        .y (p2)
    );

    online_adder #(.N(STAGE+9)) u_s (
        .x   (p1),
        .y   (p2),
        .cin (1'b0),
        .z   (s)
    );

    online_adder #(.N(STAGE+10)) u_out (
        .x   ({20'b0, din_x}),
        .y   (s),
        .cin (1'b0),
        .z   (data_out)
    );
endmodule

// File: tb/tb_online_dual_tap.sv
// Self-checking bench for online_dual_tap and its leaf cells against an integer value model.

module tb_online_dual_tap;
    localparam int STAGE = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [15:0] din_x;
    logic [37:0] data_out;

    logic [15:0] ax, ay, cx;
    logic        acin;
    logic [17:0] az;
    logic [33:0] c178, c135;

    int n_cmp = 0;
    int n_bad = 0;

    longint m1, m2;

    always #5 clk = ~clk;

    online_dual_tap #(.STAGE(STAGE)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (enable),
        .din_x    (din_x),
        .data_out (data_out)
    );

    online_adder #(.N(8)) u_add (
        .x   (ax),
        .y   (ay),
        .cin (acin),
        .z   (az)
    );

    online_ccm_178 #(.N(8)) u_c178 (
        .x (cx),
        .y (c178)
    );

    online_ccm_135 #(.N(8)) u_c135 (
        .x (cx),
        .y (c135)
    );

    function automatic longint dec(input logic [63:0] v, input int nd);
        longint acc = 0;
        for (int i = nd - 1; i >= 0; i--)
            acc = acc * 2 + (v[2*i+1] ? 1 : 0) - (v[2*i] ? 1 : 0);
        return acc;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input longint exp);
        #1;
        $display("[%s] nrst=%0b en=%0b din=%0d out=%0d exp=%0d", tag, nrst, enable,
                 dec(64'(din_x), 8), dec(64'(data_out), 19), exp);
        check(tag, dec(64'(data_out), 19), exp);
    endtask

    initial begin
        nrst = 1'b0; enable = 1'b1; din_x = 16'h0002;
        ax = '0; ay = '0; acin = 1'b0; cx = '0;

        // Reset holds the line empty; output follows din only.
        tick(); probe("rst_edge1", 1);
        tick(); probe("rst_edge2", 1);
        nrst = 1'b1;
        probe("impulse_0", 1);
        tick(); din_x = 16'h0000; probe("impulse_1", 178);
        tick(); probe("impulse_2", 135);
        tick(); probe("impulse_3", 0);
        tick(); probe("impulse_4", 0);

        din_x = 16'hAAAA; repeat (3) tick(); probe("steady_pos", 80070);
        din_x = 16'h5555; repeat (3) tick(); probe("steady_neg", -80070);
        din_x = 16'hFFFF; repeat (3) tick(); probe("steady_zero11", 0);

        // Flush on low enable, then resume from empty line.
        din_x = 16'h0002; tick(); tick();
        din_x = 16'h0008; enable = 1'b0; probe("flush_pre", 315);
        tick(); probe("flush_post", 2);
        enable = 1'b1; din_x = 16'h0002; probe("resume_0", 1);
        tick(); din_x = 16'h0000; probe("resume_1", 178);
        tick(); probe("resume_2", 135);

        // Reset asserted mid-cycle acts only at the edge.
        din_x = 16'hAAAA; tick(); tick(); probe("midrst_loaded", 80070);
        nrst = 1'b0; probe("midrst_pre", 80070);
        tick(); probe("midrst_post", 255);
        nrst = 1'b1;

        ax = 16'hAAAA; ay = 16'hAAAA; acin = 1'b1; #1;
        $display("[leaf_add_max] z=%0d", dec(64'(az), 9));
        check("leaf_add_max", dec(64'(az), 9), 511);
        ax = 16'h5555; ay = 16'hAAAA; acin = 1'b0; #1;
        $display("[leaf_add_cancel] z=%0d", dec(64'(az), 9));
        check("leaf_add_cancel", dec(64'(az), 9), 0);
        cx = 16'h5555; #1;
        $display("[leaf_c178_neg] y=%0d", dec(64'(c178), 17));
        check("leaf_c178_neg", dec(64'(c178), 17), -45390);
        cx = 16'hAAAA; #1;
        $display("[leaf_c135_pos] y=%0d", dec(64'(c135), 17));
        check("leaf_c135_pos", dec(64'(c135), 17), 34425);

        // Random leaf sweep; random bits naturally mix 00 and 11 zero digits.
        for (int i = 0; i < 10000; i++) begin
            ax = 16'($urandom); ay = 16'($urandom); acin = 1'($urandom); cx = 16'($urandom);
            #1;
            check("rand_add", dec(64'(az), 9), dec(64'(ax), 8) + dec(64'(ay), 8) + longint'(acin));
            check("rand_c178", dec(64'(c178), 17), 178 * dec(64'(cx), 8));
            check("rand_c135", dec(64'(c135), 17), 135 * dec(64'(cx), 8));
        end
        $display("[leaf_sweep] 10000 vectors done");

        // Random top-level run against a value-level delay-line model.
        nrst = 1'b0; enable = 1'b1; din_x = 16'h0000; tick();
        m1 = 0; m2 = 0;
        for (int i = 0; i < 400; i++) begin
            din_x  = 16'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            nrst   = ($urandom_range(0, 29) != 0);
            #1;
            check("rand_top", dec(64'(data_out), 19), dec(64'(din_x), 8) + 178 * m1 + 135 * m2);
            @(posedge clk);
            if (!nrst || !enable) begin
                m1 = 0; m2 = 0;
            end else begin
                m2 = m1; m1 = dec(64'(din_x), 8);
            end
            #1;
        end
        $display("[rand_top] 400 cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
